// File: rtl/store_unit_pkg.sv
// store_unit_pkg: funct3 encodings, RAM base and store-entry layout shared by the store path.
package store_unit_pkg;
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [31:0] RAM_BASE = 32'h8000_0000;
    typedef struct packed {
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } store_lane_t;
    localparam int LANE_W = $bits(store_lane_t);
    function automatic int entry_w(int addr_w);
        return addr_w + LANE_W;
    endfunction
endpackage

// File: rtl/store_unit_if.sv
// store_unit_if: core request, memory write port, load-overlap check and tohost mailbox.
interface store_unit_if #(parameter int ADDR_W = 16);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_data;
    logic              err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [31:0]       chk_addr;
    logic              chk_hit;
    logic              busy;
    logic              tohost_valid;
    logic [31:0]       tohost_data;
    modport slave (
        input  req_valid, req_funct3, req_addr, req_data, mem_ack, chk_addr,
        output req_ready, err, mem_we, mem_waddr, mem_wdata, mem_wstrb, chk_hit, busy,
               tohost_valid, tohost_data
    );
    modport master (
        output req_valid, req_funct3, req_addr, req_data, mem_ack, chk_addr,
        input  req_ready, err, mem_we, mem_waddr, mem_wdata, mem_wstrb, chk_hit, busy,
               tohost_valid, tohost_data
    );
endinterface

// File: rtl/store_unit_fifo.sv
// store_fifo: in-order entry buffer with count, full/empty and a per-entry address match.
module store_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    parameter int AW    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    input  logic [AW-1:0]              cmp_addr_i,
    output logic [DEPTH-1:0]           match_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    assign full_o  = count_q == CW'(DEPTH);
    assign empty_o = count_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + PW'(do_push);
            rd_q    <= rd_q + PW'(do_pop);
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    // An entry is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PW-1:0] age;
        assign age        = PW'(i) - rd_q;
        assign match_o[i] = ({1'b0, age} < count_q) && (mem_q[i][W-1 -: AW] == cmp_addr_i);
    end
endmodule

// File: rtl/store_unit.sv
// store_unit: validates and lane-formats SB/SH/SW, buffers them and drains to the memory write port.
// Optional STORE_TOHOST_EN diverts a valid SW to TOHOST_ADDR into a sticky mailbox.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int          DEPTH       = 2,
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000
) (
    input logic         clk,
    input logic         rst_n,
    store_unit_if.slave bus
);
    localparam int EW = entry_w(ADDR_W);
    localparam int CW = $clog2(DEPTH + 1);
    store_lane_t       lane, head_lane;
    logic              bad, accept, push, err_d, err_q, full, empty;
    logic [CW-1:0]     count;
    logic [EW-1:0]     head;
    logic [DEPTH-1:0]  match;
    logic [2:0]        f3;
    logic [31:0]       a, d;
    logic              unused_ok;
    assign f3     = bus.req_funct3;
    assign a      = bus.req_addr;
    assign d      = bus.req_data;
    assign accept = bus.req_valid && bus.req_ready;
    assign bad    = (f3 > F3_SW) || (f3 == F3_SH && a[0]) || (f3 == F3_SW && a[1:0] != 2'b00)
                 || (a[31:ADDR_W+2] != RAM_BASE[31:ADDR_W+2]);
    assign err_d  = accept && bad;
    always_comb begin
        lane.wstrb = (f3 == F3_SB) ? 4'b0001 << a[1:0] : (f3 == F3_SH) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        lane.wdata = (f3 == F3_SB) ? {4{d[7:0]}} : (f3 == F3_SH) ? {2{d[15:0]}} : d;
    end
`ifdef STORE_TOHOST_EN
    logic        to_host, th_valid_q;
    logic [31:0] th_data_q;
    assign to_host = (f3 == F3_SW) && (a == TOHOST_ADDR);
    assign push    = accept && !bad && !to_host;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th_valid_q <= 1'b0;
            th_data_q  <= '0;
        end else if (accept && !bad && to_host) begin
            th_valid_q <= 1'b1;
            th_data_q  <= d;
        end
    end
    assign bus.tohost_valid = th_valid_q;
    assign bus.tohost_data  = th_data_q;
`else
    logic unused_th;
    assign unused_th        = ^TOHOST_ADDR;
    assign push             = accept && !bad;
    assign bus.tohost_valid = 1'b0;
    assign bus.tohost_data  = '0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
    store_fifo #(.DEPTH(DEPTH), .W(EW), .AW(ADDR_W)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .data_i     ({a[ADDR_W+1:2], lane}),
        .pop_i      (bus.mem_ack),
        .head_o     (head),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .cmp_addr_i (bus.chk_addr[ADDR_W+1:2]),
        .match_o    (match)
    );
    // Ready follows the registered count only; a same-cycle pop never frees a slot early.
    assign bus.req_ready = count < CW'(DEPTH);
    assign bus.err       = err_q;
    assign bus.mem_we    = !empty;
    assign bus.busy      = !empty;
    assign head_lane     = head[LANE_W-1:0];
    assign bus.mem_waddr = head[EW-1 -: ADDR_W];
    assign bus.mem_wdata = head_lane.wdata;
    assign bus.mem_wstrb = head_lane.wstrb;
    assign bus.chk_hit   = |match;
    assign unused_ok     = ^{full, bus.chk_addr[31:ADDR_W+2], bus.chk_addr[1:0]};
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed literal checks plus randomized traffic against a queue-based model.
module tb_store_unit;
    localparam int AW = 16;
    localparam int DEPTH = 2;
    localparam logic [31:0] TH_ADDR = 32'h8000_1000;
`ifdef STORE_TOHOST_EN
    localparam bit TH_EN = 1'b1;
`else
    localparam bit TH_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;

    store_unit_if #(.ADDR_W(AW)) bus();
    store_unit #(.ADDR_W(AW), .DEPTH(DEPTH), .TOHOST_ADDR(TH_ADDR)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } ent_t;
    ent_t q[$];
    logic m_err = 1'b0;
    logic m_thv = 1'b0;
    logic [31:0] m_thd = '0;
    bit acc, ok, h;

    function automatic bit legal(logic [2:0] f3, logic [31:0] a);
        if (f3 > 3'd2) return 1'b0;
        if (a < 32'h8000_0000 || a > 32'h8003_FFFF) return 1'b0;
        return (a % (32'd1 << f3)) == 0;
    endfunction

    function automatic ent_t fmt(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        ent_t e;
        int sz = 1 << f3;
        int off = int'(a % 4);
        e.a = 16'((a - 32'h8000_0000) >> 2);
        e.s = 4'(((1 << sz) - 1) << off);
        for (int i = 0; i < 4; i++) e.d[8*i +: 8] = d[8*(i % sz) +: 8];
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(logic v, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        bus.req_valid  = v;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_data   = d;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_err = 1'b0;
            m_thv = 1'b0;
            m_thd = '0;
        end else begin
            acc = bus.req_valid && (q.size() < DEPTH);
            ok  = legal(bus.req_funct3, bus.req_addr);
            m_err = acc && !ok;
            if (bus.mem_ack && q.size() > 0) void'(q.pop_front());
            if (acc && ok) begin
                if (TH_EN && bus.req_funct3 == 3'd2 && bus.req_addr == TH_ADDR) begin
                    m_thv = 1'b1;
                    m_thd = bus.req_data;
                end else begin
                    q.push_back(fmt(bus.req_funct3, bus.req_addr, bus.req_data));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            h = 1'b0;
            foreach (q[i]) if (q[i].a == 16'((bus.chk_addr >> 2) & 32'hFFFF)) h = 1'b1;
            chk("mem_we", bus.mem_we, q.size() != 0);
            chk("busy", bus.busy, q.size() != 0);
            chk("req_ready", bus.req_ready, q.size() < DEPTH);
            chk("err", bus.err, m_err);
            chk("chk_hit", bus.chk_hit, h);
            chk("tohost_valid", bus.tohost_valid, m_thv);
            chk("tohost_data", bus.tohost_data, m_thd);
            if (q.size() != 0) begin
                chk("mem_waddr", bus.mem_waddr, q[0].a);
                chk("mem_wdata", bus.mem_wdata, q[0].d);
                chk("mem_wstrb", bus.mem_wstrb, q[0].s);
            end
        end
    end

    logic [2:0]  bf[4] = '{3'd1, 3'd2, 3'd3, 3'd2};
    logic [31:0] ba[4] = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0010, 32'h0000_0010};

    initial begin
        drv(0, 0, 0, 0);
        bus.mem_ack  = 1'b0;
        bus.chk_addr = '0;
        tick;
        tick;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_hit", bus.chk_hit, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_tohost", bus.tohost_valid, 0);
        rst_n = 1'b1;
        tick;
        // SW with ack high: visible one cycle after acceptance, gone after the ack cycle
        bus.mem_ack = 1'b1;
        drv(1, 2, 32'h8000_0010, 32'hDEAD_BEEF);
        tick;
        drv(0, 0, 0, 0);
        chk("sw_we", bus.mem_we, 1);
        chk("sw_waddr", bus.mem_waddr, 4);
        chk("sw_wstrb", bus.mem_wstrb, 4'hF);
        chk("sw_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        tick;
        chk("sw_busy_after", bus.busy, 0);
        drv(1, 0, 32'h8000_0003, 32'h0000_00A5);
        tick;
        drv(0, 0, 0, 0);
        chk("sb_wstrb", bus.mem_wstrb, 4'b1000);
        chk("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        tick;
        drv(1, 1, 32'h8000_0006, 32'h0000_1234);
        tick;
        drv(0, 0, 0, 0);
        chk("sh_wstrb", bus.mem_wstrb, 4'b1100);
        chk("sh_wdata", bus.mem_wdata, 32'h1234_1234);
        chk("sh_waddr", bus.mem_waddr, 1);
        tick;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(1, bf[i], ba[i], 32'h5555_5555);
            tick;
            drv(0, 0, 0, 0);
            chk("rej_err", bus.err, 1);
            chk("rej_we", bus.mem_we, 0);
            chk("rej_busy", bus.busy, 0);
            tick;
            chk("rej_err_clr", bus.err, 0);
        end
        drv(1, 2, 32'h8000_0014, 32'h1);
        tick;
        chk("fill1_ready", bus.req_ready, 1);
        drv(1, 2, 32'h8000_0018, 32'h2);
        tick;
        chk("fill2_ready", bus.req_ready, 0);
        drv(1, 2, 32'h8000_001C, 32'h3);
        tick;
        chk("full_ready", bus.req_ready, 0);
        chk("full_waddr", bus.mem_waddr, 5);
        chk("full_wdata", bus.mem_wdata, 1);
        bus.chk_addr = 32'h8000_0014;
        #1 chk("hit_w5", bus.chk_hit, 1);
        bus.chk_addr = 32'h8000_0020;
        #1 chk("miss_w8", bus.chk_hit, 0);
        bus.chk_addr = 32'h8000_001A;
        #1 chk("hit_w6", bus.chk_hit, 1);
        bus.mem_ack = 1'b1;
        tick;
        chk("drain_w6", bus.mem_waddr, 6);
        chk("drain_ready", bus.req_ready, 1);
        tick;
        drv(0, 0, 0, 0);
        chk("drain_w7", bus.mem_waddr, 7);
        chk("drain_d7", bus.mem_wdata, 3);
        tick;
        chk("drain_busy", bus.busy, 0);
        bus.mem_ack = 1'b0;
        drv(1, 2, 32'h8000_0020, 32'hAA);
        tick;
        drv(1, 0, 32'h8000_0025, 32'hBB);
        tick;
        drv(0, 0, 0, 0);
        chk("pre_rst_busy", bus.busy, 1);
        bus.chk_addr = 32'h8000_0024;
        #1 chk("pre_rst_hit", bus.chk_hit, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", bus.mem_we, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_hit", bus.chk_hit, 0);
        chk("mid_rst_ready", bus.req_ready, 1);
        tick;
        rst_n = 1'b1;
        tick;
        drv(1, 2, TH_ADDR, 32'h1);
        tick;
        drv(0, 0, 0, 0);
`ifdef STORE_TOHOST_EN
        chk("th_valid", bus.tohost_valid, 1);
        chk("th_data", bus.tohost_data, 1);
        chk("th_we", bus.mem_we, 0);
`else
        chk("th_mem_we", bus.mem_we, 1);
        chk("th_mem_waddr", bus.mem_waddr, 16'h0400);
        chk("th_mem_wdata", bus.mem_wdata, 1);
`endif
        bus.mem_ack = 1'b1;
        tick;
        tick;
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [2:0]  f;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = TH_ADDR;
                2:       a = 32'h8003_FFFC + $urandom_range(0, 7);
                default: a = 32'h8000_0000 + $urandom_range(0, 47);
            endcase
            f = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            drv($urandom_range(0, 9) < 7, f, a, $urandom);
            bus.mem_ack  = $urandom_range(0, 9) < 6;
            bus.chk_addr = ($urandom_range(0, 7) == 0) ? 32'h8003_FFFC : 32'h8000_0000 + $urandom_range(0, 47);
            tick;
        end
        drv(0, 0, 0, 0);
        bus.mem_ack = 1'b1;
        repeat (4) tick;
        chk("final_busy", bus.busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
